i2c_eeprom_slave: RTL and testbench

I2C responder that emulates a 24C02-style EEPROM (single-byte word address) on the board I2C bus. It is the far end of the `i2c_master_top` transactions issued by the EEPROM test design: it answers device-address ACKs, accepts byte writes and byte-address sets, and serves current-address, random and sequential reads from an internal register array. It is used as the bus target in loop-back benches and on boards without a fitted EEPROM. It also exposes every committed write to user logic.

---
 rtl/i2c_slave_pkg.sv | 21 ++
 rtl/i2c_line_filter.sv | 54 +++++
 rtl/i2c_eeprom_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared state encoding and bus-level bit constants for the I2C EEPROM responder.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_WORD_ADDR,
    ST_WORD_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a FILTER_LEN-sample glitch filter for one open-drain line.
// The filtered level and its one-cycle rise/fall strobes change on the same clock edge.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      // A new level is accepted only after FILTER_LEN consecutive differing samples.
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_MAX) begin
          level_q <= sync_q[1];
          rise_q  <= sync_q[1];
          fall_q  <= ~sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 24C02-style I2C EEPROM target: byte writes, address set, current/random/sequential reads.
// Optional write protect input is enabled with the I2C_SLAVE_WP_EN macro.
module i2c_eeprom_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         DEPTH      = 256,
  parameter int         FILTER_LEN = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
`ifdef I2C_SLAVE_WP_EN
  input  logic       wp,
`endif
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output state_t     dbg_state_o,
  output logic [7:0] dbg_ptr_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .line_i  (scl_pad_i),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .line_i  (sda_pad_i),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [AW-1:0] ptr_q;
  logic          rw_q;
  logic          ack_phase_q;
  logic          padoen_q;
  logic          busy_q;
  logic          wr_valid_q;
  logic [7:0]    wr_addr_q;
  logic [7:0]    wr_data_q;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    rd_byte;
  logic [7:0]    rx_byte;
  logic          start_det;
  logic          stop_det;
  logic          wr_allow;
  logic          byte_commit;
  logic          mem_we;

`ifdef I2C_SLAVE_WP_EN
  assign wr_allow = ~wp;
`else
  assign wr_allow = 1'b1;
`endif

  assign start_det   = sda_fall & scl_lvl;
  assign stop_det    = sda_rise & scl_lvl;
  assign rx_byte     = {shift_q[6:0], sda_lvl};
  assign rd_byte     = mem_q[ptr_q];
  assign byte_commit = (state_q == ST_WR_DATA) & scl_rise & (bit_cnt_q == 3'd7)
                     & ~start_det & ~stop_det;
  assign mem_we      = rst_n & byte_commit & wr_allow;

  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= rx_byte;
    end
  end

  // ACK states see two SCL falls: the first opens the ACK slot, the second closes it.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= I2C_RW_WRITE;
      ack_phase_q <= 1'b0;
      padoen_q    <= 1'b1;
      busy_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (start_det) begin
        state_q     <= ST_DEV_ADDR;
        bit_cnt_q   <= '0;
        ack_phase_q <= 1'b0;
        padoen_q    <= 1'b1;
      end else if (stop_det) begin
        state_q     <= ST_IDLE;
        bit_cnt_q   <= '0;
        ack_phase_q <= 1'b0;
        padoen_q    <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_DEV_ADDR: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (shift_q[6:0] == DEV_ADDR) begin
                  state_q <= ST_DEV_ACK;
                  rw_q    <= sda_lvl ? I2C_RW_READ : I2C_RW_WRITE;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          ST_DEV_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                padoen_q    <= I2C_ACK;
                ack_phase_q <= 1'b1;
              end else begin
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= '0;
                if (rw_q == I2C_RW_WRITE) begin
                  state_q  <= ST_WORD_ADDR;
                  padoen_q <= 1'b1;
                end else begin
                  state_q  <= ST_RD_DATA;
                  shift_q  <= rd_byte;
                  padoen_q <= rd_byte[7];
                end
              end
            end
          end
          ST_WORD_ADDR: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ptr_q   <= rx_byte[AW-1:0];
                state_q <= ST_WORD_ACK;
              end
            end
          end
          ST_WORD_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                padoen_q    <= I2C_ACK;
                ack_phase_q <= 1'b1;
              end else begin
                ack_phase_q <= 1'b0;
                padoen_q    <= 1'b1;
                bit_cnt_q   <= '0;
                state_q     <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (wr_allow) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= 8'(ptr_q);
                  wr_data_q  <= rx_byte;
                end
                ptr_q   <= ptr_q + AW'(1);
                state_q <= ST_WR_ACK;
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd7) begin
                padoen_q    <= 1'b1;
                bit_cnt_q   <= '0;
                ack_phase_q <= 1'b0;
                state_q     <= ST_RD_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= {shift_q[6:0], 1'b0};
                padoen_q  <= shift_q[6];
              end
            end
          end
          ST_RD_ACK: begin
            // The pointer advances after every byte served, as a real 24C02 does.
            if (scl_rise) begin
              ptr_q <= ptr_q + AW'(1);
              if (sda_lvl == I2C_NACK) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                ack_phase_q <= 1'b1;
              end
            end else if (scl_fall && ack_phase_q) begin
              ack_phase_q <= 1'b0;
              bit_cnt_q   <= '0;
              shift_q     <= rd_byte;
              padoen_q    <= rd_byte[7];
              state_q     <= ST_RD_DATA;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // wr_valid is a one-cycle strobe with no backpressure; wr_addr/wr_data hold until the next commit.
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = padoen_q;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign dbg_state_o  = state_q;
  assign dbg_ptr_o    = 8'(ptr_q);

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged I2C master, write-commit scoreboard, summary.
// The write-protect step is compiled in when I2C_SLAVE_WP_EN is defined.
module tb_i2c_eeprom_slave;
  import i2c_slave_pkg::*;

  localparam int Q = 20;

  logic       sys_clk;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda;
  logic       sda_pad_o;
  logic       sda_padoen_o;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  state_t     dbg_state;
  logic [7:0] dbg_ptr;
  wire        sda_bus = m_sda & (sda_padoen_o | sda_pad_o);
`ifdef I2C_SLAVE_WP_EN
  logic       wp;
`endif

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int wr_long = 0;
  logic       wr_prev = 1'b0;
  logic [15:0] exp_q[$];

  i2c_eeprom_slave dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
`ifdef I2C_SLAVE_WP_EN
    .wp           (wp),
`endif
    .scl_pad_i    (m_scl),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .dbg_state_o  (dbg_state),
    .dbg_ptr_o    (dbg_ptr)
  );

  // clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every wr_valid must match the oldest expected {addr,data}
  always @(negedge sys_clk) begin
    if (wr_valid) begin
      logic [31:0] exp_w;
      exp_w = (exp_q.size() > 0) ? {16'h0, exp_q.pop_front()} : 32'hFFFF_FFFF;
      chk("wr_commit", {16'h0, wr_addr, wr_data}, exp_w);
      wr_cnt++;
      if (wr_prev) wr_long++;
    end
    wr_prev = wr_valid;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; tick(Q);
    m_scl = 1'b1; tick(2 * Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = sda_bus; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(mack);
  endtask

  task automatic wr_txn(input logic [7:0] a, input logic [7:0] d, input string tag);
    logic ack;
    i2c_start();
    write_byte(8'hA0, ack); chk({tag, "_dev_ack"}, ack, 0);
    write_byte(a, ack);     chk({tag, "_word_ack"}, ack, 0);
    write_byte(d, ack);     chk({tag, "_data_ack"}, ack, 0);
    i2c_stop();
  endtask

  // random-read setup: address set, repeated START, read address; leaves bus in read phase
  task automatic rd_setup(input logic [7:0] a, input string tag);
    logic ack;
    i2c_start();
    write_byte(8'hA0, ack); chk({tag, "_dev_ack"}, ack, 0);
    chk({tag, "_busy"}, busy, 1);
    write_byte(a, ack);     chk({tag, "_word_ack"}, ack, 0);
    i2c_start();
    write_byte(8'hA1, ack); chk({tag, "_rd_ack"}, ack, 0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    rst_n = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
`ifdef I2C_SLAVE_WP_EN
    wp = 1'b0;
`endif
    tick(4);
    chk("rst_padoen", sda_padoen_o, 1);
    chk("rst_pad_o", sda_pad_o, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_ptr", dbg_ptr, 0);
    rst_n = 1'b1;
    tick(10);

    // write 00=5A, then random read back with NACK
    exp_q.push_back(16'h005A);
    wr_txn(8'h00, 8'h5A, "t1w");
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_ptr_after_wr", dbg_ptr, 8'h01);
    chk("t1_state_idle", dbg_state, ST_IDLE);
    chk("t1_busy_low", busy, 0);
    rd_setup(8'h00, "t1r");
    read_byte(1'b1, d);
    chk("t1_read", d, 8'h5A);
    chk("t1_nack_idle", dbg_state, ST_IDLE);
    i2c_stop();
    chk("t1_ptr_after_rd", dbg_ptr, 8'h01);

    // address mismatch
    i2c_start();
    write_byte(8'hA2, ack);
    chk("t2_nack", ack, 1);
    chk("t2_busy", busy, 0);
    chk("t2_state", dbg_state, ST_IDLE);
    i2c_stop();
    chk("t2_wr_cnt", wr_cnt, 1);

    // preload bytes used by later reads
    exp_q.push_back(16'h0133);
    wr_txn(8'h01, 8'h33, "pre01");
    exp_q.push_back(16'h1077);
    wr_txn(8'h10, 8'h77, "pre10");

    // wrap-around: multi-byte write at FF, then sequential read at FF
    exp_q.push_back(16'hFF11);
    exp_q.push_back(16'h0022);
    i2c_start();
    write_byte(8'hA0, ack); chk("t3_dev_ack", ack, 0);
    write_byte(8'hFF, ack); chk("t3_word_ack", ack, 0);
    write_byte(8'h11, ack); chk("t3_d0_ack", ack, 0);
    write_byte(8'h22, ack); chk("t3_d1_ack", ack, 0);
    i2c_stop();
    chk("t3_wr_cnt", wr_cnt, 5);
    chk("t3_ptr_after_wr", dbg_ptr, 8'h01);
    rd_setup(8'hFF, "t3r");
    read_byte(1'b0, d); chk("t3_rd_ff", d, 8'h11);
    read_byte(1'b0, d); chk("t3_rd_00", d, 8'h22);
    read_byte(1'b1, d); chk("t3_rd_01", d, 8'h33);
    i2c_stop();
    chk("t3_ptr_end", dbg_ptr, 8'h02);

    // STOP in the middle of a data byte
    i2c_start();
    write_byte(8'hA0, ack); chk("t4_dev_ack", ack, 0);
    write_byte(8'h10, ack); chk("t4_word_ack", ack, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    chk("t4_state", dbg_state, ST_IDLE);
    chk("t4_busy", busy, 0);
    chk("t4_wr_cnt", wr_cnt, 5);
    chk("t4_ptr", dbg_ptr, 8'h10);
    rd_setup(8'h10, "t4r");
    read_byte(1'b1, d);
    chk("t4_mem10", d, 8'h77);
    i2c_stop();

`ifdef I2C_SLAVE_WP_EN
    exp_q.push_back(16'h30C3);
    wr_txn(8'h30, 8'hC3, "t5pre");
    wp = 1'b1;
    wr_txn(8'h30, 8'hAA, "t5wp");
    chk("t5_wr_cnt", wr_cnt, 6);
    chk("t5_ptr", dbg_ptr, 8'h31);
    wp = 1'b0;
    rd_setup(8'h30, "t5r");
    read_byte(1'b1, d);
    chk("t5_mem30", d, 8'hC3);
    i2c_stop();
`endif

    // reset while the slave is pulling SDA low for bit 7 of mem[00]=22
    rd_setup(8'h00, "t6r");
    chk("t6_driving_low", sda_padoen_o, 0);
    rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("t6_released", sda_padoen_o, 1);
    chk("t6_ptr", dbg_ptr, 0);
    chk("t6_state", dbg_state, ST_IDLE);
    @(negedge sys_clk);
    rst_n = 1'b1;
    tick(Q);
    i2c_stop();
    i2c_start();
    write_byte(8'hA1, ack); chk("t6_cur_ack", ack, 0);
    read_byte(1'b1, d);
    chk("t6_cur_read", d, 8'h22);
    i2c_stop();
    chk("t6_ptr_end", dbg_ptr, 8'h01);

    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_pulse_width", wr_long, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
